// File: rtl/bank_arbiter.sv
// bank_arbiter
//
// Sits between memory mapping and the bank-side crossbars and resolves bank
// conflicts. Each accepted batch carries up to 2P lane requests, and each
// request is tagged with a target bank. Every grant cycle the arbiter gives
// each bank at most one lane. It keeps granting until every enabled lane of
// the batch has been served. The per-bank lane selects are packed exactly
// like the sel_BI_bus field layout that the bank input crossbar expects.
//
// Optional feature macro: BANK_ARB_RR_EN
//   undefined : fixed priority, lowest lane index wins.
//   defined   : per-bank round-robin pointer. The search starts at rr[k] and
//               wraps around. The pointer persists across batches.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   in_valid       a request batch is presented
//   in_ready       the batch is accepted on an edge with in_valid && in_ready
//   req_en_bus     bit j   : lane j carries a real request
//   BI_bus         field j : target bank of lane j
//   sel_BI_bus     field k : lane granted to bank k (registered)
//   bank_en_bus    bit k   : bank k has a granted access (registered)
//   lane_done_bus  bit j   : lane j served this cycle (registered)
//   out_valid      grant outputs are meaningful (registered)
//   last           final grant cycle of the batch (registered)
//
// The lane count 2P is assumed to be a power of two (2P == 2**MAP). With that
// assumption, the round-robin search wraps by plain MAP-bit overflow.

module bank_arbiter #(
  parameter int P       = 2,
  parameter int MAP     = $clog2(2*P),
  parameter int BI_PACK = 2*P*MAP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*P-1:0]     req_en_bus,
  input  logic [BI_PACK-1:0] BI_bus,
  output logic [BI_PACK-1:0] sel_BI_bus,
  output logic [2*P-1:0]     bank_en_bus,
  output logic [2*P-1:0]     lane_done_bus,
  output logic               out_valid,
  output logic               last
);

  localparam int N = 2*P;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q;
  logic [N-1:0]       pend_q;
  logic [BI_PACK-1:0] bi_q;

  logic [BI_PACK-1:0] sel_q;
  logic [N-1:0]       bank_en_q;
  logic [N-1:0]       lane_done_q;
  logic               out_valid_q;
  logic               last_q;

`ifdef BANK_ARB_RR_EN
  logic [BI_PACK-1:0] rr_q;
`endif

  logic [BI_PACK-1:0] sel_d;
  logic [N-1:0]       bank_en_d;
  logic [N-1:0]       grant;
  logic [N-1:0]       rem;
  logic               found;
  logic [MAP-1:0]     idx;
  logic [MAP-1:0]     cand;
  logic               accept;

  // Winner search. Offsets are scanned from the highest to the lowest, so
  // the last match found is the one nearest the start point. The start point
  // is lane 0 for fixed priority, or rr[k] for round-robin.
  always_comb begin
    grant     = '0;
    sel_d     = '0;
    bank_en_d = '0;
    found     = 1'b0;
    idx       = '0;
    cand      = '0;
    if (state_q == GRANT) begin
      for (int k = 0; k < N; k++) begin
        found = 1'b0;
        idx   = '0;
        for (int o = N-1; o >= 0; o--) begin
`ifdef BANK_ARB_RR_EN
          cand = rr_q[k*MAP +: MAP] + MAP'(o);
`else
          cand = MAP'(o);
`endif
          if (pend_q[cand] && (bi_q[int'(cand)*MAP +: MAP] == MAP'(k))) begin
            found = 1'b1;
            idx   = cand;
          end
        end
        if (found) begin
          sel_d[k*MAP +: MAP] = idx;
          bank_en_d[k]        = 1'b1;
          grant[idx]          = 1'b1;
        end
      end
    end
  end

  // Lanes that are still waiting after this cycle's grants. When this is
  // zero, the current cycle is the batch's last one and a new batch can be
  // taken on the same edge.
  assign rem      = pend_q & ~grant;
  assign in_ready = !rst && ((state_q == IDLE) || (rem == '0));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      sel_q       <= '0;
      bank_en_q   <= '0;
      lane_done_q <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
`ifdef BANK_ARB_RR_EN
      rr_q        <= '0;
`endif
    end else begin
      // Grant results are all zero outside GRANT, so these loads also
      // clear the outputs on idle cycles.
      sel_q       <= sel_d;
      bank_en_q   <= bank_en_d;
      lane_done_q <= grant;
      out_valid_q <= (state_q == GRANT);
      last_q      <= (state_q == GRANT) && (rem == '0);

      if (accept) begin
        pend_q  <= req_en_bus;
        state_q <= (req_en_bus != '0) ? GRANT : IDLE;
      end else if (state_q == GRANT) begin
        pend_q <= rem;
        if (rem == '0) begin
          state_q <= IDLE;
        end
      end

`ifdef BANK_ARB_RR_EN
      for (int k = 0; k < N; k++) begin
        if (bank_en_d[k]) begin
          rr_q[k*MAP +: MAP] <= sel_d[k*MAP +: MAP] + MAP'(1);
        end
      end
`endif
    end
  end

  // Bank targets are pure data. They are only read while pend_q marks them
  // live, so they do not need a reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      bi_q <= BI_bus;
    end
  end

  assign sel_BI_bus    = sel_q;
  assign bank_en_bus   = bank_en_q;
  assign lane_done_bus = lane_done_q;
  assign out_valid     = out_valid_q;
  assign last          = last_q;

endmodule

// File: tb/tb_bank_arbiter.sv
module tb_bank_arbiter;

  localparam int P       = 2;
  localparam int MAP     = 2;
  localparam int BI_PACK = 8;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         req_en_bus;
  logic [BI_PACK-1:0] BI_bus;
  logic [BI_PACK-1:0] sel_BI_bus;
  logic [3:0]         bank_en_bus;
  logic [3:0]         lane_done_bus;
  logic               out_valid;
  logic               last;

  int checks;
  int errors;

  bank_arbiter #(.P(P), .MAP(MAP), .BI_PACK(BI_PACK)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .req_en_bus    (req_en_bus),
    .BI_bus        (BI_bus),
    .sel_BI_bus    (sel_BI_bus),
    .bank_en_bus   (bank_en_bus),
    .lane_done_bus (lane_done_bus),
    .out_valid     (out_valid),
    .last          (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pack4(input int f0, input int f1, input int f2, input int f3);
    pack4 = {2'(f3), 2'(f2), 2'(f1), 2'(f0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic lst,
                         input logic [7:0] sel, input logic [3:0] ben, input logic [3:0] ld);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".last"}, 32'(last), 32'(lst));
    chk({tag, ".sel"}, 32'(sel_BI_bus), 32'(sel));
    chk({tag, ".bank_en"}, 32'(bank_en_bus), 32'(ben));
    chk({tag, ".lane_done"}, 32'(lane_done_bus), 32'(ld));
  endtask

  // Advance to one time unit past the next rising edge (start of next cycle).
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] bx, by, bz, sx, sy, sz, ball1;
  int         ord0, ord1, ord2;

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    req_en_bus = '0;
    BI_bus     = '0;
    bx    = pack4(2, 0, 3, 1);  sx = pack4(1, 3, 0, 2);
    by    = pack4(0, 1, 2, 3);  sy = pack4(0, 1, 2, 3);
    bz    = pack4(3, 2, 1, 0);  sz = pack4(3, 2, 1, 0);
    ball1 = pack4(1, 1, 1, 1);

    // ---------------- reset ----------------
    next();
    next();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk_out("rst", 1'b0, 1'b0, 8'h00, 4'h0, 4'h0);
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);

    // ---------------- conflict-free ----------------
    in_valid = 1'b1; req_en_bus = 4'b1111; BI_bus = bx;   // cycle 0
    chk("cf.c0.in_ready", 32'(in_ready), 32'd1);
    next(); in_valid = 1'b0;                              // cycle 1
    chk("cf.c1.out_valid", 32'(out_valid), 32'd0);
    next();                                               // cycle 2
    chk_out("cf.c2", 1'b1, 1'b1, sx, 4'hF, 4'hF);
    next();                                               // cycle 3
    chk("cf.c3.out_valid", 32'(out_valid), 32'd0);

    // ---------------- full conflict ----------------
    in_valid = 1'b1; req_en_bus = 4'b1111; BI_bus = ball1; // cycle 0
    next(); in_valid = 1'b0;                               // cycle 1
    chk("fc.c1.in_ready", 32'(in_ready), 32'd0);
    next();                                                // cycle 2
    chk_out("fc.c2", 1'b1, 1'b0, pack4(0, 0, 0, 0), 4'b0010, 4'b0001);
    chk("fc.c2.in_ready", 32'(in_ready), 32'd0);
    next();                                                // cycle 3
    chk_out("fc.c3", 1'b1, 1'b0, pack4(0, 1, 0, 0), 4'b0010, 4'b0010);
    chk("fc.c3.in_ready", 32'(in_ready), 32'd0);
    next();                                                // cycle 4
    chk_out("fc.c4", 1'b1, 1'b0, pack4(0, 2, 0, 0), 4'b0010, 4'b0100);
    chk("fc.c4.in_ready", 32'(in_ready), 32'd1);
    next();                                                // cycle 5
    chk_out("fc.c5", 1'b1, 1'b1, pack4(0, 3, 0, 0), 4'b0010, 4'b1000);
    next();                                                // cycle 6
    chk("fc.c6.out_valid", 32'(out_valid), 32'd0);

    // ---------------- empty batch ----------------
    in_valid = 1'b1; req_en_bus = 4'b0000; BI_bus = bx;   // cycle 0
    chk("emp.c0.in_ready", 32'(in_ready), 32'd1);
    next(); in_valid = 1'b0;
    chk("emp.c1.in_ready", 32'(in_ready), 32'd1);
    chk("emp.c1.out_valid", 32'(out_valid), 32'd0);
    next();
    chk_out("emp.c2", 1'b0, 1'b0, 8'h00, 4'h0, 4'h0);
    next();
    chk("emp.c3.out_valid", 32'(out_valid), 32'd0);

    // ---------------- back-to-back ----------------
    in_valid = 1'b1; req_en_bus = 4'b1111; BI_bus = bx;   // cycle 0
    chk("b2b.c0.in_ready", 32'(in_ready), 32'd1);
    next(); BI_bus = by;                                  // cycle 1
    chk("b2b.c1.in_ready", 32'(in_ready), 32'd1);
    next(); BI_bus = bz;                                  // cycle 2
    chk("b2b.c2.in_ready", 32'(in_ready), 32'd1);
    chk_out("b2b.c2", 1'b1, 1'b1, sx, 4'hF, 4'hF);
    next(); in_valid = 1'b0;                              // cycle 3
    chk_out("b2b.c3", 1'b1, 1'b1, sy, 4'hF, 4'hF);
    next();                                               // cycle 4
    chk_out("b2b.c4", 1'b1, 1'b1, sz, 4'hF, 4'hF);
    next();                                               // cycle 5
    chk("b2b.c5.out_valid", 32'(out_valid), 32'd0);

    // ---------------- reset mid-batch ----------------
    in_valid = 1'b1; req_en_bus = 4'b1111; BI_bus = ball1; // cycle 0
    next(); in_valid = 1'b0;                               // cycle 1
    next();                                                // cycle 2
    chk("rmb.c2.lane_done", 32'(lane_done_bus), 32'h1);
    next(); rst = 1'b1;                                    // cycle 3
    #1;
    chk("rmb.c3.in_ready", 32'(in_ready), 32'd0);
    chk("rmb.c3.lane_done", 32'(lane_done_bus), 32'h2);
    next(); rst = 1'b0;                                    // cycle 4
    #1;
    chk_out("rmb.c4", 1'b0, 1'b0, 8'h00, 4'h0, 4'h0);
    chk("rmb.c4.in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; req_en_bus = 4'b1111; BI_bus = bx;
    next(); in_valid = 1'b0;                               // cycle 5
    chk_out("rmb.c5", 1'b0, 1'b0, 8'h00, 4'h0, 4'h0);
    next();                                                // cycle 6
    chk_out("rmb.c6", 1'b1, 1'b1, sx, 4'hF, 4'hF);
    next();                                                // cycle 7
    chk("rmb.c7.out_valid", 32'(out_valid), 32'd0);

    // ---------------- priority order (fresh pointers after reset) ----------------
    rst = 1'b1;
    next();
    rst = 1'b0;
    next();
`ifdef BANK_ARB_RR_EN
    ord0 = 3; ord1 = 0; ord2 = 1;
`else
    ord0 = 0; ord1 = 1; ord2 = 3;
`endif
    in_valid = 1'b1; req_en_bus = 4'b0011; BI_bus = pack4(1, 1, 0, 0); // cycle 0: A
    next(); in_valid = 1'b0;                                           // cycle 1
    chk("pri.c1.in_ready", 32'(in_ready), 32'd0);
    next();                                                            // cycle 2
    chk_out("pri.A0", 1'b1, 1'b0, pack4(0, 0, 0, 0), 4'b0010, 4'b0001);
    chk("pri.c2.in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; req_en_bus = 4'b1011; BI_bus = pack4(1, 1, 0, 1); // B
    next(); in_valid = 1'b0;                                           // cycle 3
    chk_out("pri.A1", 1'b1, 1'b1, pack4(0, 1, 0, 0), 4'b0010, 4'b0010);
    next();                                                            // cycle 4
    chk_out("pri.B0", 1'b1, 1'b0, pack4(0, ord0, 0, 0), 4'b0010, 4'(1 << ord0));
    next();                                                            // cycle 5
    chk_out("pri.B1", 1'b1, 1'b0, pack4(0, ord1, 0, 0), 4'b0010, 4'(1 << ord1));
    next();                                                            // cycle 6
    chk_out("pri.B2", 1'b1, 1'b1, pack4(0, ord2, 0, 0), 4'b0010, 4'(1 << ord2));
    next();                                                            // cycle 7
    chk("pri.c7.out_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bank_arbiter.md
# bank_arbiter

Conflict-resolving arbiter between memory mapping and the bank-side crossbars. Each accepted batch holds up to 2P lane requests, each tagged with a target bank index. The block resolves bank conflicts over as many cycles as the worst-case bank collision needs. Each grant cycle it emits per-bank lane selects in the exact `sel_BI_bus` packing that the bank input crossbar consumes.

## Interface
Parameters (macros from `parameter.v`):
- `P`, 2: lanes = banks = 2P.
- `MAP`, log2(2P): width of one bank index or one lane index.
- `BI_PACK`, 2P*MAP: packed index bus width. Field i occupies bits [i*MAP+MAP-1 : i*MAP].

Ports:
- `clk`  in  1  — clock.
- `rst`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — a request batch is presented.
- `in_ready`  out  1  — batch accepted on an edge where `in_valid && in_ready`.
- `req_en_bus`  in  2P  — bit j: lane j carries a real request.
- `BI_bus`  in  BI_PACK  — field j: target bank of lane j.
- `sel_BI_bus`  out  BI_PACK  — field k: lane index granted to bank k this cycle.
- `bank_en_bus`  out  2P  — bit k: bank k has a granted access this cycle.
- `lane_done_bus`  out  2P  — bit j: lane j served this cycle.
- `out_valid`  out  1  — grant outputs are meaningful.
- `last`  out  1  — final grant cycle of the current batch.

## Operation
- State `IDLE`:
  - On acceptance, latch `bi_q <= BI_bus` and `pend <= req_en_bus`.
  - Go to `GRANT` if `req_en_bus != 0`.
  - A batch with all-zero `req_en_bus` is accepted and dropped: state stays `IDLE` and no `out_valid` is produced.
- State `GRANT`, every cycle:
  - For each bank k, pick the winner among pending lanes j with `bi_q[j] == k`. Default priority is lowest j.
  - Combinational `grant` = set of winners, at most one per bank.
  - On the edge, the output registers load the result:
    - `sel_BI[k]` = winner, `bank_en[k]` = 1.
    - `lane_done` = grant.
    - `out_valid` = 1.
    - `last` = (`pend & ~grant` == 0).
  - Update `pend <= pend & ~grant`.
- Final cycle: when `pend & ~grant == 0`, this is the final grant cycle.
  - If a new batch is accepted in the same cycle, latch it and stay in `GRANT` (or go to `IDLE` if its `req_en` is zero).
  - Otherwise go to `IDLE`.
- `in_ready` = !rst && (state==`IDLE` || (state==`GRANT` && (pend & ~grant)==0)).
- Banks without a winner: `sel_BI[k]` = 0, `bank_en[k]` = 0.
- On cycles not loaded from `GRANT`, all output registers load 0.
- Grant cycles per batch = max over banks of the number of enabled lanes targeting that bank (1..2P).
- Every `BI` value is a legal bank index; no range checking is done.

## Timing
- Reset: state `IDLE`, `pend` = 0.
  - While `rst` is high, `in_ready` = 0.
  - `sel_BI_bus`, `bank_en_bus`, `lane_done_bus`, `out_valid`, `last` are all 0 on the cycle after the reset edge.
- Reset mid-batch: the pending batch is discarded and no further grants are issued. `in_ready` = 1 in the first cycle after `rst` falls.
- Latency: batch accepted in cycle c → first grant outputs in cycle c+2.
- Throughput:
  - Conflict-free batches: one per cycle, back-to-back.
  - A batch needing N grant cycles holds `in_ready` low for N-1 cycles.
- Downstream has no backpressure. Banks consume grants in the cycle they are shown.

## Configuration
- `BANK_ARB_RR_EN` defined:
  - Each bank k keeps a MAP-bit priority pointer `rr[k]`, reset to 0.
  - The winner is the first pending lane at or after `rr[k]`, searching circularly.
  - On each grant to bank k, `rr[k] <= winner+1` mod 2P. Pointers persist across batches.
- Undefined: fixed lowest-lane-index priority, with no pointer registers.

## Test plan
All scenarios use P=2 (4 lanes/banks, MAP=2).
- Conflict-free: BI = {lane0:2, lane1:0, lane2:3, lane3:1}, req_en=1111, accept in cycle 0 → cycle 2 shows sel_BI {bank0:1, bank1:3, bank2:0, bank3:2}, bank_en=1111, lane_done=1111, last=1; cycle 3 shows out_valid=0.
- Full conflict: all lanes to bank 1 → cycles 2..5 show sel_BI[1] = 0,1,2,3 with bank_en=0010; last=1 only in cycle 5; in_ready low in cycles 1..3 and high in cycle 4.
- Empty batch: req_en=0000 with in_valid → accepted, in_ready stays 1, out_valid never asserts.
- Back-to-back: three conflict-free batches in cycles 0,1,2 → out_valid=1 and last=1 in cycles 2,3,4, each with the matching selects.
- Reset mid-batch: full-conflict batch, rst asserted in cycle 3 → outputs all 0 from cycle 4, no further grants; a new batch is accepted in the first cycle after rst falls.
- `BANK_ARB_RR_EN`:
  - Batch A has lanes 0,1 → bank 1; then batch B has lanes 0,1,3 → bank 1.
  - With the macro, B is granted in order 3,0,1.
  - Without the macro, B is granted in order 0,1,3.
